// File: rtl/arb_mux_n_v.sv
// arb_mux_n_v: N-channel mux with direct-select or round-robin arbitration
// feeding a single registered output slot with ready/valid handshake.
`default_nettype none

module arb_mux_n_v #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_mode,
  input  logic [SEL_W-1:0]      i_sel_code,
  input  logic [N_CH-1:0]       i_valid,
  input  logic [N_CH*WIDTH-1:0] i_data,
  output logic [N_CH-1:0]       o_ready,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic [SEL_W-1:0]      o_ch,
  input  logic                  i_ready
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] cand;
  logic             cand_ok;
  logic [SEL_W-1:0] rr_idx;
  logic             load;
  logic             grant;

  // Round-robin search starts just after ptr and visits ptr itself last.
  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    rr_idx  = '0;
    if (!i_mode) begin
      cand    = i_sel_code;
      cand_ok = i_valid[i_sel_code];
    end else begin
      for (int i = 1; i <= N_CH; i++) begin
        rr_idx = ptr + SEL_W'(i);
        if (!cand_ok && i_valid[rr_idx]) begin
          cand    = rr_idx;
          cand_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    load    = i_en && !i_rst && (!o_valid || i_ready);
    grant   = load && cand_ok;
    o_ready = '0;
    if (grant) begin
      o_ready[cand] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      ptr     <= SEL_W'(N_CH - 1);
    end else if (grant) begin
      o_valid <= 1'b1;
      o_data  <= i_data[cand*WIDTH +: WIDTH];
      o_ch    <= cand;
      if (i_mode) begin
        ptr <= cand;
      end
    end else if (o_valid && i_ready) begin
      // Empty slot reads as all zeros.
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_arb_mux_n_v.sv
// tb_arb_mux_n_v: directed self-checking bench for arb_mux_n_v.
`default_nettype none

module tb_arb_mux_n_v;

  logic        clk;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  sel_code;
  logic [3:0]  valid;
  logic [31:0] data;
  logic [3:0]  ready_out;
  logic        valid_out;
  logic [7:0]  data_out;
  logic [1:0]  ch_out;
  logic        ready_in;

  int tests;
  int fails;

  arb_mux_n_v #(.WIDTH(8), .N_CH(4), .SEL_W(2)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_mode     (mode),
    .i_sel_code (sel_code),
    .i_valid    (valid),
    .i_data     (data),
    .o_ready    (ready_out),
    .o_valid    (valid_out),
    .o_data     (data_out),
    .o_ch       (ch_out),
    .i_ready    (ready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; checks happen 1ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    data = {d3, d2, d1, d0};
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; valid = 4'b0000; ready_in = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b1; valid = 4'b1111; ready_in = 1'b1;
    set_data(8'h01, 8'h02, 8'h03, 8'h04);
    #1;
    tests++;
    if (ready_out !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b want 0000", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ch_out !== 2'd0) begin
      fails++; $display("FAIL reset_state: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                        valid_out, data_out, ch_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct();
    do_reset();
    en = 1'b1; mode = 1'b0; sel_code = 2'd2; valid = 4'b0100; ready_in = 1'b1;
    set_data(8'h11, 8'h22, 8'hA5, 8'h44);
    #1;
    tests++;
    if (ready_out !== 4'b0100) begin
      fails++; $display("FAIL direct_ready: got %b want 0100", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b1 || data_out !== 8'hA5 || ch_out !== 2'd2) begin
      fails++; $display("FAIL direct_load: got v=%b d=%h ch=%0d want v=1 d=a5 ch=2",
                        valid_out, data_out, ch_out);
    end
    // Selected channel not requesting: no grant, held word drains.
    sel_code = 2'd1;
    #1;
    tests++;
    if (ready_out !== 4'b0000) begin
      fails++; $display("FAIL direct_nogrant: got %b want 0000", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ch_out !== 2'd0) begin
      fails++; $display("FAIL direct_drain: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                        valid_out, data_out, ch_out);
    end
    // Mode-0 grant above left ptr at 3, so round-robin picks channel 0.
    mode = 1'b1; valid = 4'b1111;
    #1;
    tests++;
    if (ready_out !== 4'b0001) begin
      fails++; $display("FAIL direct_ptr_kept: got %b want 0001", ready_out);
    end
  endtask

  task automatic test_rr_all();
    logic [1:0] exp_seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_d;
    do_reset();
    en = 1'b1; mode = 1'b1; valid = 4'b1111; ready_in = 1'b1;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    for (int i = 0; i < 5; i++) begin
      #1;
      tests++;
      if (ready_out !== (4'b0001 << exp_seq[i])) begin
        fails++; $display("FAIL rr_all_ready[%0d]: got %b want ch %0d", i, ready_out, exp_seq[i]);
      end
      tick();
      exp_d = 8'h10 + 8'(exp_seq[i]);
      tests++;
      if (valid_out !== 1'b1 || ch_out !== exp_seq[i] || data_out !== exp_d) begin
        fails++; $display("FAIL rr_all_out[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h",
                          i, valid_out, ch_out, data_out, exp_seq[i], exp_d);
      end
    end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_seq [4] = '{2'd0, 2'd3, 2'd0, 2'd3};
    do_reset();
    en = 1'b1; mode = 1'b1; valid = 4'b1001; ready_in = 1'b1;
    set_data(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (ready_out !== (4'b0001 << exp_seq[i])) begin
        fails++; $display("FAIL rr_sparse_ready[%0d]: got %b want ch %0d", i, ready_out, exp_seq[i]);
      end
      tick();
      tests++;
      if (valid_out !== 1'b1 || ch_out !== exp_seq[i]) begin
        fails++; $display("FAIL rr_sparse_out[%0d]: got v=%b ch=%0d want v=1 ch=%0d",
                          i, valid_out, ch_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; mode = 1'b0; sel_code = 2'd1; valid = 4'b0010; ready_in = 1'b1;
    set_data(8'h00, 8'h11, 8'h22, 8'h33);
    tick();
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel_code = 2'(i + 2);
      valid    = 4'b1111;
      set_data(8'(i), 8'(i + 8), 8'h5A, 8'h33);
      mode     = i[0];
      #1;
      tests++;
      if (ready_out !== 4'b0000) begin
        fails++; $display("FAIL hold_ready[%0d]: got %b want 0000", i, ready_out);
      end
      tick();
      tests++;
      if (valid_out !== 1'b1 || data_out !== 8'h11 || ch_out !== 2'd1) begin
        fails++; $display("FAIL hold_stable[%0d]: got v=%b d=%h ch=%0d want v=1 d=11 ch=1",
                          i, valid_out, data_out, ch_out);
      end
    end
    mode = 1'b0; sel_code = 2'd3; ready_in = 1'b1;
    #1;
    tests++;
    if (ready_out !== 4'b1000) begin
      fails++; $display("FAIL hold_release_ready: got %b want 1000", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b1 || data_out !== 8'h33 || ch_out !== 2'd3) begin
      fails++; $display("FAIL hold_release_load: got v=%b d=%h ch=%0d want v=1 d=33 ch=3",
                        valid_out, data_out, ch_out);
    end
  endtask

  task automatic test_enable_drain();
    en = 1'b0; mode = 1'b1; valid = 4'b1111; ready_in = 1'b1;
    #1;
    tests++;
    if (ready_out !== 4'b0000) begin
      fails++; $display("FAIL en_ready: got %b want 0000", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ch_out !== 2'd0) begin
      fails++; $display("FAIL en_drain: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                        valid_out, data_out, ch_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0 || ready_out !== 4'b0000) begin
      fails++; $display("FAIL en_idle: got v=%b rdy=%b want v=0 rdy=0000", valid_out, ready_out);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; mode = 1'b1; valid = 4'b1111; ready_in = 1'b1;
    set_data(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    tick();
    tick();
    tests++;
    if (valid_out !== 1'b1 || ch_out !== 2'd1 || data_out !== 8'hE1) begin
      fails++; $display("FAIL rstmid_setup: got v=%b ch=%0d d=%h want v=1 ch=1 d=e1",
                        valid_out, ch_out, data_out);
    end
    ready_in = 1'b0; rst = 1'b1;
    #1;
    tests++;
    if (ready_out !== 4'b0000) begin
      fails++; $display("FAIL rstmid_ready: got %b want 0000", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || ch_out !== 2'd0) begin
      fails++; $display("FAIL rstmid_clear: got v=%b d=%h ch=%0d want v=0 d=00 ch=0",
                        valid_out, data_out, ch_out);
    end
    rst = 1'b0; ready_in = 1'b1;
    #1;
    tests++;
    if (ready_out !== 4'b0001) begin
      fails++; $display("FAIL rstmid_first: got %b want 0001", ready_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b1 || ch_out !== 2'd0 || data_out !== 8'hE0) begin
      fails++; $display("FAIL rstmid_load: got v=%b ch=%0d d=%h want v=1 ch=0 d=e0",
                        valid_out, ch_out, data_out);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel_code = 2'd0;
    valid = 4'b0000; data = 32'h0; ready_in = 1'b0;
    tick();
    test_reset();
    test_direct();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_enable_drain();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
